// File: rtl/reorder_buffer_3way.sv
// reorder_buffer_3way: in-order retirement buffer with 3-wide allocate, writeback and commit.
// Commit outputs are combinational from registered state; they release old physical registers.
module reorder_buffer_3way #(
    parameter int DEPTH           = 32,
    parameter int IDX_WIDTH       = 5,
    parameter int ARCH_ADDR_WIDTH = 5,
    parameter int PHYS_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 alloc_valid,
    input  logic                       alloc_has_rd_0,
    input  logic                       alloc_has_rd_1,
    input  logic                       alloc_has_rd_2,
    input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_0,
    input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_1,
    input  logic [ARCH_ADDR_WIDTH-1:0] alloc_rd_arch_2,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_rd_phys_0,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_rd_phys_1,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_rd_phys_2,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_old_rd_phys_0,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_old_rd_phys_1,
    input  logic [PHYS_ADDR_WIDTH-1:0] alloc_old_rd_phys_2,
    output logic                       alloc_ready,
    output logic [IDX_WIDTH-1:0]       alloc_idx_0,
    output logic [IDX_WIDTH-1:0]       alloc_idx_1,
    output logic [IDX_WIDTH-1:0]       alloc_idx_2,
    input  logic [2:0]                 wb_valid,
    input  logic [IDX_WIDTH-1:0]       wb_idx_0,
    input  logic [IDX_WIDTH-1:0]       wb_idx_1,
    input  logic [IDX_WIDTH-1:0]       wb_idx_2,
    input  logic                       flush,
    output logic [2:0]                 commit_valid,
    output logic [PHYS_ADDR_WIDTH-1:0] free_phys_reg_0,
    output logic [PHYS_ADDR_WIDTH-1:0] free_phys_reg_1,
    output logic [PHYS_ADDR_WIDTH-1:0] free_phys_reg_2,
    output logic [ARCH_ADDR_WIDTH-1:0] commit_rd_arch_0,
    output logic [ARCH_ADDR_WIDTH-1:0] commit_rd_arch_1,
    output logic [ARCH_ADDR_WIDTH-1:0] commit_rd_arch_2,
    output logic [PHYS_ADDR_WIDTH-1:0] commit_rd_phys_0,
    output logic [PHYS_ADDR_WIDTH-1:0] commit_rd_phys_1,
    output logic [PHYS_ADDR_WIDTH-1:0] commit_rd_phys_2,
    output logic [IDX_WIDTH:0]         rob_count,
    output logic                       rob_empty,
    output logic                       rob_full
);
    localparam logic [IDX_WIDTH:0] ALLOC_LIMIT = (IDX_WIDTH+1)'(DEPTH - 3);
    localparam logic [IDX_WIDTH:0] FULL_COUNT  = (IDX_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0]           valid_q, done_q, has_rd_q;
    logic [ARCH_ADDR_WIDTH-1:0] rd_arch_q     [DEPTH];
    logic [PHYS_ADDR_WIDTH-1:0] rd_phys_q     [DEPTH];
    logic [PHYS_ADDR_WIDTH-1:0] old_rd_phys_q [DEPTH];
    logic [IDX_WIDTH-1:0]       head_q, tail_q;
    logic [IDX_WIDTH:0]         count_q;

    logic [2:0]                 in_has_rd;
    logic [ARCH_ADDR_WIDTH-1:0] in_arch  [3];
    logic [PHYS_ADDR_WIDTH-1:0] in_phys  [3];
    logic [PHYS_ADDR_WIDTH-1:0] in_old   [3];
    logic [IDX_WIDTH-1:0]       in_wb    [3];
    logic [IDX_WIDTH-1:0]       a_idx    [3];
    logic [IDX_WIDTH-1:0]       c_idx    [3];
    logic [2:0]                 cv;
    logic [PHYS_ADDR_WIDTH-1:0] out_free [3];
    logic [ARCH_ADDR_WIDTH-1:0] out_arch [3];
    logic [PHYS_ADDR_WIDTH-1:0] out_phys [3];
    logic [1:0]                 n_alloc, n_commit;

    assign in_has_rd = {alloc_has_rd_2, alloc_has_rd_1, alloc_has_rd_0};
    assign in_arch[0] = alloc_rd_arch_0;
    assign in_arch[1] = alloc_rd_arch_1;
    assign in_arch[2] = alloc_rd_arch_2;
    assign in_phys[0] = alloc_rd_phys_0;
    assign in_phys[1] = alloc_rd_phys_1;
    assign in_phys[2] = alloc_rd_phys_2;
    assign in_old[0]  = alloc_old_rd_phys_0;
    assign in_old[1]  = alloc_old_rd_phys_1;
    assign in_old[2]  = alloc_old_rd_phys_2;
    assign in_wb[0]   = wb_idx_0;
    assign in_wb[1]   = wb_idx_1;
    assign in_wb[2]   = wb_idx_2;

    assign alloc_ready = (count_q <= ALLOC_LIMIT);
    assign rob_count   = count_q;
    assign rob_empty   = (count_q == '0);
    assign rob_full    = (count_q == FULL_COUNT);

    // Valid slots are compacted onto consecutive entries starting at tail.
    always_comb begin
        logic [1:0] offs;
        offs = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            a_idx[k] = tail_q + IDX_WIDTH'(offs);
            offs     = offs + {1'b0, alloc_valid[k]};
        end
        n_alloc = alloc_ready ? offs : 2'd0;
    end

    always_comb begin
        logic run;
        run      = ~flush;
        n_commit = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            c_idx[k]    = head_q + IDX_WIDTH'(k);
            run         = run & valid_q[c_idx[k]] & done_q[c_idx[k]];
            cv[k]       = run;
            n_commit    = n_commit + {1'b0, run};
            out_free[k] = '0;
            out_arch[k] = '0;
            out_phys[k] = '0;
            if (run && has_rd_q[c_idx[k]]) begin
                out_free[k] = old_rd_phys_q[c_idx[k]];
                out_arch[k] = rd_arch_q[c_idx[k]];
                out_phys[k] = rd_phys_q[c_idx[k]];
            end
        end
    end

    assign alloc_idx_0      = a_idx[0];
    assign alloc_idx_1      = a_idx[1];
    assign alloc_idx_2      = a_idx[2];
    assign commit_valid     = cv;
    assign free_phys_reg_0  = out_free[0];
    assign free_phys_reg_1  = out_free[1];
    assign free_phys_reg_2  = out_free[2];
    assign commit_rd_arch_0 = out_arch[0];
    assign commit_rd_arch_1 = out_arch[1];
    assign commit_rd_arch_2 = out_arch[2];
    assign commit_rd_phys_0 = out_phys[0];
    assign commit_rd_phys_1 = out_phys[1];
    assign commit_rd_phys_2 = out_phys[2];

    // Ordering: writeback, then commit clear, then allocation; the last write to a bit wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned p = 0; p < 3; p++) begin
                if (wb_valid[p] && valid_q[in_wb[p]]) begin
                    done_q[in_wb[p]] <= 1'b1;
                end
            end
            for (int unsigned k = 0; k < 3; k++) begin
                if (cv[k]) begin
                    valid_q[c_idx[k]] <= 1'b0;
                    done_q[c_idx[k]]  <= 1'b0;
                end
            end
            if (alloc_ready) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    if (alloc_valid[k]) begin
                        valid_q[a_idx[k]] <= 1'b1;
                        done_q[a_idx[k]]  <= 1'b0;
                    end
                end
            end
            head_q  <= head_q + IDX_WIDTH'(n_commit);
            tail_q  <= tail_q + IDX_WIDTH'(n_alloc);
            count_q <= count_q + (IDX_WIDTH+1)'(n_alloc) - (IDX_WIDTH+1)'(n_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_ready && !flush) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (alloc_valid[k]) begin
                    has_rd_q[a_idx[k]]      <= in_has_rd[k];
                    rd_arch_q[a_idx[k]]     <= in_arch[k];
                    rd_phys_q[a_idx[k]]     <= in_phys[k];
                    old_rd_phys_q[a_idx[k]] <= in_old[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_3way.sv
// Bench for reorder_buffer_3way: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer_3way;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alloc_valid, wb_valid;
    logic       flush;
    logic       a_has_rd [3];
    logic [4:0] a_arch   [3];
    logic [5:0] a_phys   [3];
    logic [5:0] a_old    [3];
    logic [4:0] wb_idx   [3];
    logic       alloc_ready, rob_empty, rob_full;
    logic [4:0] o_aidx   [3];
    logic [2:0] commit_valid;
    logic [5:0] o_free   [3];
    logic [4:0] o_carch  [3];
    logic [5:0] o_cphys  [3];
    logic [5:0] rob_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int idx;
        bit has_rd;
        int arch;
        int phys;
        int old;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_head = 0;

    reorder_buffer_3way #(
        .DEPTH(32), .IDX_WIDTH(5), .ARCH_ADDR_WIDTH(5), .PHYS_ADDR_WIDTH(6)
    ) dut (
        .clk(clk), .reset(reset), .alloc_valid(alloc_valid),
        .alloc_has_rd_0(a_has_rd[0]), .alloc_has_rd_1(a_has_rd[1]), .alloc_has_rd_2(a_has_rd[2]),
        .alloc_rd_arch_0(a_arch[0]), .alloc_rd_arch_1(a_arch[1]), .alloc_rd_arch_2(a_arch[2]),
        .alloc_rd_phys_0(a_phys[0]), .alloc_rd_phys_1(a_phys[1]), .alloc_rd_phys_2(a_phys[2]),
        .alloc_old_rd_phys_0(a_old[0]), .alloc_old_rd_phys_1(a_old[1]), .alloc_old_rd_phys_2(a_old[2]),
        .alloc_ready(alloc_ready),
        .alloc_idx_0(o_aidx[0]), .alloc_idx_1(o_aidx[1]), .alloc_idx_2(o_aidx[2]),
        .wb_valid(wb_valid), .wb_idx_0(wb_idx[0]), .wb_idx_1(wb_idx[1]), .wb_idx_2(wb_idx[2]),
        .flush(flush), .commit_valid(commit_valid),
        .free_phys_reg_0(o_free[0]), .free_phys_reg_1(o_free[1]), .free_phys_reg_2(o_free[2]),
        .commit_rd_arch_0(o_carch[0]), .commit_rd_arch_1(o_carch[1]), .commit_rd_arch_2(o_carch[2]),
        .commit_rd_phys_0(o_cphys[0]), .commit_rd_phys_1(o_cphys[1]), .commit_rd_phys_2(o_cphys[2]),
        .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic idle();
        alloc_valid = '0;
        wb_valid    = '0;
        flush       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_has_rd[k] = 1'b0;
            a_arch[k]   = '0;
            a_phys[k]   = '0;
            a_old[k]    = '0;
            wb_idx[k]   = '0;
        end
    endtask

    task automatic rand_payload();
        for (int k = 0; k < 3; k++) begin
            a_has_rd[k] = 1'($urandom);
            a_arch[k]   = 5'($urandom);
            a_phys[k]   = 6'($urandom);
            a_old[k]    = 6'($urandom);
        end
    endtask

    // Check outputs against the model mid-cycle, then advance model and DUT by one edge.
    task automatic cycle();
        int   cnt, tail, off, n, exp_ready;
        int   e_idx [3];
        int   ef, ea, ep;
        ent_t e;
        @(negedge clk);
        cnt       = q.size();
        tail      = (m_head + cnt) % DEPTH;
        exp_ready = (DEPTH - cnt >= 3) ? 1 : 0;
        off       = 0;
        for (int k = 0; k < 3; k++) begin
            e_idx[k] = (tail + off) % DEPTH;
            off      = off + int'(alloc_valid[k]);
        end
        n = 0;
        if (!flush) while (n < 3 && n < cnt && q[n].done) n++;

        chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
        chk("rob_count", 32'(rob_count), 32'(cnt));
        chk("rob_empty", 32'(rob_empty), 32'(cnt == 0));
        chk("rob_full", 32'(rob_full), 32'(cnt == DEPTH));
        chk("commit_valid", 32'(commit_valid), 32'((1 << n) - 1));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("alloc_idx_%0d", k), 32'(o_aidx[k]), 32'(e_idx[k]));
            ef = 0; ea = 0; ep = 0;
            if (k < n && q[k].has_rd) begin
                ef = q[k].old; ea = q[k].arch; ep = q[k].phys;
            end
            chk($sformatf("free_phys_reg_%0d", k), 32'(o_free[k]), 32'(ef));
            chk($sformatf("commit_rd_arch_%0d", k), 32'(o_carch[k]), 32'(ea));
            chk($sformatf("commit_rd_phys_%0d", k), 32'(o_cphys[k]), 32'(ep));
        end

        if (flush) begin
            q.delete();
            m_head = 0;
        end else begin
            for (int p = 0; p < 3; p++)
                if (wb_valid[p])
                    foreach (q[i]) if (q[i].idx == int'(wb_idx[p])) q[i].done = 1'b1;
            repeat (n) void'(q.pop_front());
            m_head = (m_head + n) % DEPTH;
            if (exp_ready != 0)
                for (int k = 0; k < 3; k++)
                    if (alloc_valid[k]) begin
                        e.idx    = e_idx[k];
                        e.has_rd = a_has_rd[k];
                        e.arch   = int'(a_arch[k]);
                        e.phys   = int'(a_phys[k]);
                        e.old    = int'(a_old[k]);
                        e.done   = 1'b0;
                        q.push_back(e);
                    end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        int n;
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            idle();
            n = 0;
            foreach (q[i])
                if (!q[i].done && n < 3) begin
                    wb_valid[n] = 1'b1;
                    wb_idx[n]   = 5'(q[i].idx);
                    n++;
                end
            cycle();
            guard++;
        end
        chk("drain_remaining", 32'(q.size()), 32'd0);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12;
        chk("reset_commit_valid", 32'(commit_valid), 32'd0);
        chk("reset_alloc_idx_2", 32'(o_aidx[2]), 32'd0);
        chk("reset_free_0", 32'(o_free[0]), 32'd0);
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_count", 32'(rob_count), 32'd0);
        chk("reset_empty", 32'(rob_empty), 32'd1);
        chk("reset_full", 32'(rob_full), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First group of three, completed out of order.
        alloc_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            a_has_rd[k] = 1'b1;
            a_arch[k]   = 5'(5 + k);
            a_phys[k]   = 6'(32 + k);
            a_old[k]    = 6'(1 + k);
        end
        #1;
        chk("first_alloc_idx_2", 32'(o_aidx[2]), 32'd2);
        cycle();
        idle();
        #1;
        chk("first_count", 32'(rob_count), 32'd3);
        chk("first_no_commit", 32'(commit_valid), 32'd0);
        for (int i = 2; i >= 0; i--) begin
            wb_valid  = 3'b001;
            wb_idx[0] = 5'(i);
            cycle();
        end
        idle();
        #1;
        chk("group_commit_valid", 32'(commit_valid), 32'd7);
        chk("group_free_0", 32'(o_free[0]), 32'd1);
        chk("group_free_2", 32'(o_free[2]), 32'd3);
        cycle();
        chk("group_empty_after", 32'(rob_empty), 32'd1);

        // Sparse allocation, slot 0 without destination.
        alloc_valid = 3'b101;
        a_has_rd[0] = 1'b0; a_arch[0] = 5'd9;  a_phys[0] = 6'd41; a_old[0] = 6'd9;
        a_has_rd[2] = 1'b1; a_arch[2] = 5'd12; a_phys[2] = 6'd40; a_old[2] = 6'd10;
        #1;
        chk("sparse_idx_0", 32'(o_aidx[0]), 32'd3);
        chk("sparse_idx_2", 32'(o_aidx[2]), 32'd4);
        cycle();
        idle();
        wb_valid = 3'b011; wb_idx[0] = 5'd3; wb_idx[1] = 5'd4;
        cycle();
        idle();
        #1;
        chk("sparse_commit_valid", 32'(commit_valid), 32'd3);
        chk("sparse_free_0_no_rd", 32'(o_free[0]), 32'd0);
        chk("sparse_free_1", 32'(o_free[1]), 32'd10);
        cycle();

        // Fill to 30: further requests are ignored.
        for (int i = 0; i < 10; i++) begin
            alloc_valid = 3'b111;
            rand_payload();
            cycle();
        end
        idle();
        #1;
        chk("fill30_ready", 32'(alloc_ready), 32'd0);
        chk("fill30_count", 32'(rob_count), 32'd30);
        alloc_valid = 3'b111;
        cycle();
        idle();
        #1;
        chk("fill30_count_held", 32'(rob_count), 32'd30);

        // Flush beats alloc/wb and blocks a ready commit.
        wb_valid = 3'b001; wb_idx[0] = 5'd5;
        cycle();
        idle();
        flush = 1'b1; alloc_valid = 3'b111; wb_valid = 3'b111;
        wb_idx[0] = 5'd6; wb_idx[1] = 5'd7; wb_idx[2] = 5'd8;
        #1;
        chk("flush_commit_blocked", 32'(commit_valid), 32'd0);
        cycle();
        idle();
        #1;
        chk("flush_count", 32'(rob_count), 32'd0);
        chk("flush_tail", 32'(o_aidx[0]), 32'd0);

        // Reach full through one 2-wide group.
        alloc_valid = 3'b011;
        rand_payload();
        cycle();
        for (int i = 0; i < 10; i++) begin
            alloc_valid = 3'b111;
            rand_payload();
            cycle();
        end
        idle();
        #1;
        chk("full_flag", 32'(rob_full), 32'd1);
        chk("full_count", 32'(rob_count), 32'd32);
        flush = 1'b1;
        cycle();
        idle();

        // Move head to 30, then a group straddling the wrap.
        for (int i = 0; i < 10; i++) begin
            alloc_valid = 3'b111;
            rand_payload();
            cycle();
        end
        drain();
        alloc_valid = 3'b111;
        rand_payload();
        #1;
        chk("wrap_idx_0", 32'(o_aidx[0]), 32'd30);
        chk("wrap_idx_1", 32'(o_aidx[1]), 32'd31);
        chk("wrap_idx_2", 32'(o_aidx[2]), 32'd0);
        cycle();
        idle();
        wb_valid = 3'b111; wb_idx[0] = 5'd30; wb_idx[1] = 5'd31; wb_idx[2] = 5'd0;
        cycle();
        idle();
        #1;
        chk("wrap_commit_valid", 32'(commit_valid), 32'd7);
        cycle();
        chk("wrap_tail_after", 32'(o_aidx[0]), 32'd1);
        chk("wrap_empty_after", 32'(rob_empty), 32'd1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            alloc_valid = 3'($urandom);
            rand_payload();
            for (int k = 0; k < 3; k++) begin
                wb_valid[k] = ($urandom_range(0, 3) != 0);
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_idx[k] = 5'(q[$urandom_range(0, q.size() - 1)].idx);
                else
                    wb_idx[k] = 5'($urandom);
            end
            flush = ($urandom_range(0, 63) == 0);
            cycle();
        end

        // Asynchronous reset mid-cycle.
        idle();
        alloc_valid = 3'b111;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_count", 32'(rob_count), 32'd0);
        chk("async_reset_empty", 32'(rob_empty), 32'd1);
        chk("async_reset_commit", 32'(commit_valid), 32'd0);
        q.delete();
        m_head = 0;
        idle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
